// File: rtl/pzhsbus_packet_fifo.sv
// Packet-aware hsbus FIFO: store-and-forward or word (cut-through) mode,
// with word/packet counters, almost-full flag and oversize-packet recovery.
module pzhsbus_packet_fifo #(
  parameter  int WIDTH       = 32,
  parameter  int DEPTH       = 16,
  parameter  int THRESHOLD   = DEPTH - 2,
  parameter  bit PACKET_MODE = 1'b1,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_slave_valid,
  output logic                   o_slave_ready,
  input  logic [WIDTH-1:0]       i_slave_payload,
  input  logic                   i_slave_last,
  output logic                   o_master_valid,
  input  logic                   i_master_ready,
  output logic [WIDTH-1:0]       o_master_payload,
  output logic                   o_master_last,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_almost_full,
  output logic [COUNT_WIDTH-1:0] o_word_count,
  output logic [COUNT_WIDTH-1:0] o_packet_count,
  output logic                   o_oversize
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCED = 1'b1
  } state_e;

  // Each entry holds {last, payload}; storage is never reset or cleared.
  logic [WIDTH:0]         mem_q [DEPTH];

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic [COUNT_WIDTH-1:0] packet_count_q, packet_count_d;
  state_e                 state_q, state_d;
  logic                   oversize_q, oversize_d;

  logic push;
  logic pop;
  logic pkt_in;
  logic pkt_out;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags come straight from the registered counters, so ready never
  // depends combinationally on i_master_ready.
  assign o_empty        = (word_count_q == '0);
  assign o_full         = (word_count_q == COUNT_WIDTH'(DEPTH));
  assign o_almost_full  = (word_count_q >= COUNT_WIDTH'(THRESHOLD));
  assign o_word_count   = word_count_q;
  assign o_packet_count = packet_count_q;
  assign o_oversize     = oversize_q;
  assign o_slave_ready  = ~o_full;
  assign o_master_valid = PACKET_MODE
                          ? (~o_empty & ((packet_count_q != '0) | (state_q == ST_FORCED)))
                          : ~o_empty;
  assign o_master_payload = mem_q[rd_ptr_q][WIDTH-1:0];
  assign o_master_last    = mem_q[rd_ptr_q][WIDTH];

  assign push    = i_slave_valid & o_slave_ready;
  assign pop     = o_master_valid & i_master_ready;
  assign pkt_in  = push & i_slave_last;
  assign pkt_out = pop & o_master_last;

  // Next pointer and counter values; clear flushes everything to zero.
  always_comb begin
    wr_ptr_d       = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d       = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    word_count_d   = word_count_q;
    packet_count_d = packet_count_q;
    case ({push, pop})
      2'b10:   word_count_d = word_count_q + 1'b1;
      2'b01:   word_count_d = word_count_q - 1'b1;
      default: word_count_d = word_count_q;
    endcase
    case ({pkt_in, pkt_out})
      2'b10:   packet_count_d = packet_count_q + 1'b1;
      2'b01:   packet_count_d = packet_count_q - 1'b1;
      default: packet_count_d = packet_count_q;
    endcase
    if (i_clear) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      word_count_d   = '0;
      packet_count_d = '0;
    end
  end

  // Oversize FSM: a full FIFO with no complete packet can never release one,
  // so fall back to cut-through until the packet's last beat leaves.
  always_comb begin
    state_d    = state_q;
    oversize_d = 1'b0;
    if (PACKET_MODE) begin
      case (state_q)
        ST_NORMAL: begin
          if (o_full && (packet_count_q == '0)) begin
            state_d    = ST_FORCED;
            oversize_d = 1'b1;
          end
        end
        ST_FORCED: begin
          if (pkt_out) state_d = ST_NORMAL;
        end
        default: state_d = ST_NORMAL;
      endcase
    end
    if (i_clear) begin
      state_d    = ST_NORMAL;
      oversize_d = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      word_count_q   <= '0;
      packet_count_q <= '0;
      state_q        <= ST_NORMAL;
      oversize_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      word_count_q   <= word_count_d;
      packet_count_q <= packet_count_d;
      state_q        <= state_d;
      oversize_q     <= oversize_d;
    end
  end

  // Beat storage write; contents are don't-care until pointed at.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_slave_last, i_slave_payload};
  end

endmodule

// File: tb/tb_pzhsbus_packet_fifo.sv
// Directed bench: packet-mode instance (default parameters) and word-mode instance.
module tb_pzhsbus_packet_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Packet-mode instance signals
  logic        p_clear, p_svalid, p_sready, p_slast, p_mvalid, p_mready, p_mlast;
  logic [31:0] p_spay, p_mpay;
  logic        p_empty, p_full, p_afull, p_over;
  logic [4:0]  p_wcnt, p_pcnt;

  // Word-mode instance signals
  logic        w_clear, w_svalid, w_sready, w_slast, w_mvalid, w_mready, w_mlast;
  logic [31:0] w_spay, w_mpay;
  logic        w_empty, w_full, w_afull, w_over;
  logic [4:0]  w_wcnt, w_pcnt;

  pzhsbus_packet_fifo u_pkt (
    .i_clk(clk), .i_rst(rst), .i_clear(p_clear),
    .i_slave_valid(p_svalid), .o_slave_ready(p_sready),
    .i_slave_payload(p_spay), .i_slave_last(p_slast),
    .o_master_valid(p_mvalid), .i_master_ready(p_mready),
    .o_master_payload(p_mpay), .o_master_last(p_mlast),
    .o_empty(p_empty), .o_full(p_full), .o_almost_full(p_afull),
    .o_word_count(p_wcnt), .o_packet_count(p_pcnt), .o_oversize(p_over)
  );

  pzhsbus_packet_fifo #(.PACKET_MODE(1'b0)) u_word (
    .i_clk(clk), .i_rst(rst), .i_clear(w_clear),
    .i_slave_valid(w_svalid), .o_slave_ready(w_sready),
    .i_slave_payload(w_spay), .i_slave_last(w_slast),
    .o_master_valid(w_mvalid), .i_master_ready(w_mready),
    .o_master_payload(w_mpay), .o_master_last(w_mlast),
    .o_empty(w_empty), .o_full(w_full), .o_almost_full(w_afull),
    .o_word_count(w_wcnt), .o_packet_count(w_pcnt), .o_oversize(w_over)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_pkt(input string tag);
    chk({tag, "_empty"}, p_empty, 1);
    chk({tag, "_sready"}, p_sready, 1);
    chk({tag, "_mvalid"}, p_mvalid, 0);
    chk({tag, "_wcnt"}, p_wcnt, 0);
    chk({tag, "_pcnt"}, p_pcnt, 0);
    chk({tag, "_full"}, p_full, 0);
    chk({tag, "_afull"}, p_afull, 0);
    chk({tag, "_over"}, p_over, 0);
  endtask

  logic [31:0] q[$];
  int pushed;
  int cyc;

  initial begin
    rst = 1'b1;
    p_clear = 0; p_svalid = 0; p_spay = 0; p_slast = 0; p_mready = 0;
    w_clear = 0; w_svalid = 0; w_spay = 0; w_slast = 0; w_mready = 0;

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle_pkt("rst");
      chk("rst_w_empty", w_empty, 1);
      chk("rst_w_mvalid", w_mvalid, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle_pkt("idle");
    end

    // 4-beat packet, master not ready
    for (int i = 0; i < 4; i++) begin
      p_svalid = 1; p_spay = 32'hA0 + i; p_slast = (i == 3);
      chk("pk4_hold_valid", p_mvalid, 0);
      tick();
    end
    p_svalid = 0; p_slast = 0;
    chk("pk4_valid", p_mvalid, 1);
    chk("pk4_pcnt", p_pcnt, 1);
    chk("pk4_wcnt", p_wcnt, 4);
    p_mready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("pk4_pop_valid", p_mvalid, 1);
      chk("pk4_data", p_mpay, 32'hA0 + i);
      chk("pk4_last", p_mlast, (i == 3));
      tick();
    end
    p_mready = 0;
    chk("pk4_empty", p_empty, 1);
    chk("pk4_pcnt0", p_pcnt, 0);

    // Oversize packet: 16 beats, no last
    for (int i = 0; i < 16; i++) begin
      p_svalid = 1; p_spay = 32'h100 + i; p_slast = 0;
      tick();
      chk("ovr_afull", p_afull, (i + 1 >= 14));
      chk("ovr_full", p_full, (i + 1 == 16));
    end
    p_svalid = 0;
    chk("ovr_sready", p_sready, 0);
    chk("ovr_pre_valid", p_mvalid, 0);
    chk("ovr_pre_pulse", p_over, 0);
    tick();
    chk("ovr_pulse", p_over, 1);
    chk("ovr_valid", p_mvalid, 1);
    tick();
    chk("ovr_pulse_end", p_over, 0);
    p_mready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("ovr_data", p_mpay, 32'h100 + i);
      tick();
      chk("ovr_no_repulse", p_over, 0);
    end
    p_mready = 0;
    chk("ovr_drained", p_empty, 1);
    p_svalid = 1; p_spay = 32'h1FF; p_slast = 1;
    tick();
    p_svalid = 0; p_slast = 0;
    chk("ovr_tail_valid", p_mvalid, 1);
    chk("ovr_tail_last", p_mlast, 1);
    p_mready = 1;
    tick();
    p_mready = 0;
    // Back in NORMAL: 2-beat packet must wait for its last beat
    p_svalid = 1; p_spay = 32'hB0; p_slast = 0;
    tick();
    chk("norm_wait", p_mvalid, 0);
    p_spay = 32'hB1; p_slast = 1;
    tick();
    p_svalid = 0; p_slast = 0;
    chk("norm_valid", p_mvalid, 1);
    p_mready = 1;
    chk("norm_d0", p_mpay, 32'hB0);
    tick();
    chk("norm_d1", p_mpay, 32'hB1);
    chk("norm_l1", p_mlast, 1);
    tick();
    p_mready = 0;
    chk("norm_empty", p_empty, 1);

    // Wrap-around: 40 single-beat packets, consumer always ready
    p_mready = 1;
    for (int i = 0; i < 40; i++) begin
      p_svalid = 1; p_spay = 32'h200 + i; p_slast = 1;
      if (i > 0) begin
        chk("wrap_valid", p_mvalid, 1);
        chk("wrap_data", p_mpay, 32'h200 + i - 1);
        chk("wrap_wcnt", p_wcnt, 1);
      end
      tick();
    end
    p_svalid = 0; p_slast = 0;
    chk("wrap_tail", p_mpay, 32'h227);
    tick();
    p_mready = 0;
    chk("wrap_empty", p_empty, 1);

    // Clear with a complete packet and a partial one stored
    for (int i = 0; i < 5; i++) begin
      p_svalid = 1; p_spay = 32'h300 + i; p_slast = (i == 2);
      tick();
    end
    p_svalid = 0; p_slast = 0;
    chk("clr_pre_wcnt", p_wcnt, 5);
    chk("clr_pre_pcnt", p_pcnt, 1);
    p_clear = 1;
    tick();
    p_clear = 0;
    chk_idle_pkt("clr");
    p_svalid = 1; p_spay = 32'hC0; p_slast = 0;
    tick();
    chk("clr_wait", p_mvalid, 0);
    p_spay = 32'hC1; p_slast = 1;
    tick();
    p_svalid = 0; p_slast = 0;
    p_mready = 1;
    chk("clr_d0", p_mpay, 32'hC0);
    chk("clr_v0", p_mvalid, 1);
    tick();
    chk("clr_d1", p_mpay, 32'hC1);
    chk("clr_l1", p_mlast, 1);
    tick();
    p_mready = 0;
    chk("clr_empty", p_empty, 1);

    // Word mode: fill to 8, then simultaneous push/pop keeps count
    for (int i = 0; i < 8; i++) begin
      w_svalid = 1; w_spay = 32'h400 + i;
      chk("w_fill_valid", w_mvalid, (i != 0));
      q.push_back(w_spay);
      tick();
    end
    chk("w_cnt8", w_wcnt, 8);
    w_spay = 32'h408; w_mready = 1;
    chk("w_sim_data", w_mpay, q[0]);
    void'(q.pop_front());
    q.push_back(w_spay);
    tick();
    w_svalid = 0; w_mready = 0;
    chk("w_sim_cnt8", w_wcnt, 8);

    // Word mode: random valid/ready, order and count against a queue model
    pushed = 0;
    cyc = 0;
    while ((pushed < 1000 || q.size() != 0) && cyc < 20000) begin
      w_svalid = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      w_spay   = $urandom;
      w_mready = $urandom_range(0, 1);
      chk("w_cnt", w_wcnt, q.size());
      chk("w_cnt_max", (w_wcnt <= 5'd16), 1);
      chk("w_valid", w_mvalid, (q.size() != 0));
      chk("w_sready", w_sready, (q.size() != 16));
      if (w_mvalid && w_mready && q.size() != 0) begin
        chk("w_data", w_mpay, q[0]);
        void'(q.pop_front());
      end
      if (w_svalid && w_sready) begin
        q.push_back(w_spay);
        pushed++;
      end
      tick();
      cyc++;
    end
    w_svalid = 0; w_mready = 0;
    chk("w_timeout", (cyc < 20000), 1);
    chk("w_end_empty", w_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pzhsbus_packet_fifo.md
Name: pzhsbus_packet_fifo

Overview:
- Parametrised successor to the plain hsbus FIFO. Buffers hsbus beats that carry a `last` flag.
- Adds two modes: store-and-forward packet mode and plain word (cut-through) mode. Also adds packet counting, an almost-full threshold, and oversize-packet recovery.
- Sits between hsbus producers and consumers that need whole packets before forwarding, e.g. ahead of arbiters and DMA engines.

Parameters:
- WIDTH, 32, payload width in bits excluding `last`.
- DEPTH, 16, storage depth in beats; must be >= 2.
- THRESHOLD, DEPTH-2, `o_almost_full` asserts when word count >= THRESHOLD.
- PACKET_MODE, 1, 1 = store-and-forward; 0 = word mode (output valid whenever non-empty).
- COUNT_WIDTH, $clog2(DEPTH+1), width of the word and packet counters (derived, not overridable).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_clear  input  1  synchronous flush of contents; pointers and counters go to 0.
- i_slave_valid  input  1  input beat valid.
- o_slave_ready  output  1  input beat accepted when valid&ready.
- i_slave_payload  input  WIDTH  input data.
- i_slave_last  input  1  marks final beat of a packet.
- o_master_valid  output  1  output beat available.
- i_master_ready  input  1  consumer accepts beat.
- o_master_payload  output  WIDTH  output data.
- o_master_last  output  1  last flag of output beat.
- o_empty  output  1  word count == 0.
- o_full  output  1  word count == DEPTH.
- o_almost_full  output  1  word count >= THRESHOLD.
- o_word_count  output  COUNT_WIDTH  stored beats.
- o_packet_count  output  COUNT_WIDTH  complete packets stored (last-flagged beats in storage).
- o_oversize  output  1  one-cycle pulse when forced cut-through is entered.

Interface: one clock `i_clk`; reset `i_rst` is synchronous and active-high.

Behaviour:
- Reset (`i_rst`=1 at a rising edge): pointers, `o_word_count` and `o_packet_count` are 0, FSM goes to NORMAL.
  - Outputs after reset: `o_empty`=1, `o_full`=0, `o_almost_full`=0, `o_slave_ready`=1, `o_master_valid`=0, `o_oversize`=0.
  - Payload and last are don't-care.
  - Reset mid-packet discards all stored and partial data.
- `i_clear` has the same effect as reset except storage contents are not touched. `i_rst` has priority over `i_clear`.
- Push: `o_slave_ready` = ~`o_full`. Push = `i_slave_valid` & `o_slave_ready`. The write pointer increments and wraps DEPTH-1 -> 0.
- Pop: pop = `o_master_valid` & `i_master_ready`. The read pointer increments and wraps.
- `o_master_payload`/`o_master_last` are driven from the entry at the read pointer, read combinationally from the register array.
- Latency: a beat pushed in cycle N is visible at the output in cycle N+1 at the earliest (word mode, or packet mode with its last beat pushed).
- Word count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop while full is impossible because ready=0.
  - Simultaneous push and pop while empty is impossible because valid=0.
- Packet count: +1 on push with last=1, -1 on pop with last=1, unchanged when both occur in the same cycle.
- `o_master_valid`:
  - PACKET_MODE=0: ~`o_empty`.
  - PACKET_MODE=1: ~`o_empty` & (`o_packet_count` != 0 | state==FORCED).
- FSM (only active when PACKET_MODE=1; held in NORMAL otherwise):
  - NORMAL -> FORCED when `o_full`=1 and `o_packet_count`=0 (a packet larger than DEPTH). `o_oversize` pulses for 1 cycle on this transition.
  - FORCED: beats drain as in word mode.
  - FORCED -> NORMAL on the cycle a beat with last=1 is popped.
  - `i_clear`/`i_rst` force NORMAL.
- Packets of exactly DEPTH beats do not trigger FORCED: once the last beat is written, packet count is 1.
- A packet of 1 beat (last=1 on first beat) is valid.
- `o_packet_count` never exceeds DEPTH.
- All flags are registered-counter derived. No combinational path from `i_master_ready` to `o_slave_ready`.

Test Plan:
- Reset then idle -> `o_empty`=1, `o_slave_ready`=1, `o_master_valid`=0, counts 0 for every cycle of reset and after.
- PACKET_MODE=1, DEPTH=16: push a 4-beat packet (0xA0..0xA3, last on A3) with the master not ready.
  - `o_master_valid` stays 0 through beat A2.
  - `o_master_valid` asserts the cycle after A3 is pushed, with `o_packet_count`=1.
  - Popping yields A0..A3 with last only on A3.
- PACKET_MODE=1, DEPTH=16: push 16 beats with no last -> `o_full`=1, `o_oversize` pulses once, `o_master_valid`=1.
  - Drain 16 beats.
  - Push 1 more beat with last=1 and pop it -> FSM returns to NORMAL.
  - The next 2-beat packet waits for its last beat before valid.
- PACKET_MODE=0: random valid/ready for 1000 beats -> output order equals input order, and word count never exceeds 16.
  - Simultaneous push and pop at count 8 keeps the count at 8.
- Wrap-around: 40 single-beat packets with `i_master_ready`=1 -> each popped 1 cycle after push, pointers wrap twice, no data loss.
- `i_clear` asserted with 5 beats stored (1 complete packet) -> the next cycle has counts 0, `o_empty`=1, FSM NORMAL.
  - A new packet afterwards is delivered intact.
